gate_stim_seq: RTL and testbench
================================

Name: gate_stim_seq

Overview:
- Upstream stimulus stage for the two-input basic gates block.
- Drives the shared inputs a and b through all four combinations in the order 00, 01, 10, 11.
- Holds each combination for a programmable number of cycles, repeats for a programmable number of passes, and reports progress through a start/busy/done handshake.
- Provides a sample strobe so a downstream capture or checker knows when the gate outputs are settled.

Parameters:
- DWELL, 10, cycles each vector is held; must be >= 1.
- LOOPS, 1, number of full 4-vector passes; 0 = run continuously until stop.
- CNT_W, 16, width of the pass counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level sampled each clk; begins a run when in IDLE.
- stop  in  1  aborts an active run.
- a  out  1  gate input a (registered).
- b  out  1  gate input b (registered).
- vec_idx  out  2  current vector index; {a,b} == vec_idx.
- vec_valid  out  1  high in the last dwell cycle of each vector (sample point).
- busy  out  1  high while in DRIVE.
- done  out  1  one-cycle pulse on normal completion.
- pass_cnt  out  CNT_W  completed passes since the last start.

Behaviour:
- Reset (async, rst=1): state=IDLE, a=0, b=0, vec_idx=0, vec_valid=0, busy=0, done=0, pass_cnt=0, dwell counter=0.
- All outputs are registered. a = vec_idx[1], b = vec_idx[0].
- State IDLE:
  - start=1 and stop=0 -> next cycle DRIVE, with vec_idx=0, dwell=0, pass_cnt=0, busy=1.
  - start=1 and stop=1 in the same cycle: stop wins, remain IDLE.
- State DRIVE:
  - Dwell counter runs 0..DWELL-1; vec_valid=1 exactly when dwell==DWELL-1.
  - On the vec_valid cycle: dwell returns to 0 and vec_idx increments, wrapping 3 -> 0.
  - On the 3 -> 0 wrap: pass_cnt increments; it wraps modulo 2^CNT_W.
  - If LOOPS != 0 and the incremented pass_cnt == LOOPS -> DONE.
  - With DWELL=1, vec_valid is high every DRIVE cycle.
- State DONE (one cycle): done=1, busy=0, vec_valid=0, vec_idx=0 (a=b=0), pass_cnt held -> IDLE.
- stop=1 in DRIVE: next cycle IDLE, busy=0, a=b=0, vec_idx=0, vec_valid=0, no done pulse, pass_cnt holds the passes completed so far.
- start while busy or in DONE: ignored. A new start is accepted only in IDLE.
- rst asserted mid-run: immediate return to reset values; no done pulse.
- Latency with LOOPS=N:
  - done is asserted 1 + 4*DWELL*N cycles after the start-sampling edge.
  - First vector appears on a/b one cycle after start is sampled.

Optional Feature:
GATE_SEQ_CHECK_EN
- Defined: adds the following ports.
  - input y [6:0]: the gate block outputs y0..y6 as bit 0..6.
  - output err_cnt [7:0]: saturating at 255, cleared on accepted start and on reset.
  - output first_err_idx [1:0]: vec_idx of the first mismatch since start; valid when err_cnt != 0; reset 0.
- On each vec_valid cycle, y is compared with the expected value; any bit mismatch increments err_cnt by 1 (once per vector, not per bit).
- Expected values from current a/b: y0=a&b, y1=a|b, y2=~(a&b), y3=~(a|b), y4=a^b, y5=~(a^b), y6=~a.
- Undefined: the y, err_cnt and first_err_idx ports and the checking logic do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset value check: hold rst=1 mid-DRIVE with DWELL=4 -> all outputs drop to 0 asynchronously, before the next clk edge; after release, state is IDLE and start is required again.
- Normal run, DWELL=2, LOOPS=1: start pulse sampled at edge 0 -> {a,b} = 00,00,01,01,10,10,11,11 on cycles 1-8; vec_valid=1 on cycles 2,4,6,8; done=1 on cycle 9; pass_cnt=1; busy=1 on cycles 1-8 only.
- Multi-pass, DWELL=1, LOOPS=3: start -> 12 DRIVE cycles, vec_idx sequence 0,1,2,3 repeated 3 times, done at cycle 13, pass_cnt=3.
- Abort, DWELL=3, LOOPS=0: start, run 20 cycles (one full pass done), assert stop -> next cycle busy=0, a=b=0, no done, pass_cnt=1; start+stop together in IDLE -> stays IDLE.
- Start ignored while busy: DWELL=2, LOOPS=1, pulse start again on cycle 4 -> sequence unchanged, single done at cycle 9.
- GATE_SEQ_CHECK_EN, DWELL=2, LOOPS=1:
  - Correct gate model on y -> err_cnt=0 at done.
  - Force y4 stuck at 0 -> err_cnt=2 (vectors 01 and 10), first_err_idx=1.

Source files
------------

// File: rtl/gate_stim_seq.sv
// Stimulus sequencer for the two-input gates block: walks {a,b} through 00,01,10,11.
// Optional macro GATE_SEQ_CHECK_EN adds an on-line checker of the gate outputs y[6:0].
module gate_stim_seq #(
  parameter int DWELL = 10,
  parameter int LOOPS = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
`ifdef GATE_SEQ_CHECK_EN
  input  logic [6:0]       y,
  output logic [7:0]       err_cnt,
  output logic [1:0]       first_err_idx,
`endif
  output logic             a,
  output logic             b,
  output logic [1:0]       vec_idx,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level sampled every clk but only honoured in IDLE (stop wins);
  // busy covers every DRIVE cycle, done pulses for one cycle on normal completion only.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] LOOPS_C   = CNT_W'(LOOPS);

  state_e           state_q, state_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             vec_valid_q, vec_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic             start_acc;

  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    dwell_d     = dwell_q;
    pass_cnt_d  = pass_cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    vec_valid_d = 1'b0;
    start_acc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          start_acc   = 1'b1;
          state_d     = S_DRIVE;
          vec_idx_d   = 2'd0;
          dwell_d     = '0;
          pass_cnt_d  = '0;
          busy_d      = 1'b1;
          vec_valid_d = (DWELL_LAST == '0);
        end
      end
      S_DRIVE: begin
        if (stop) begin
          state_d   = S_IDLE;
          vec_idx_d = 2'd0;
          dwell_d   = '0;
        end else begin
          busy_d = 1'b1;
          if (dwell_q == DWELL_LAST) begin
            dwell_d   = '0;
            vec_idx_d = vec_idx_q + 2'd1;
            if (vec_idx_q == 2'd3) begin
              pass_cnt_d = pass_cnt_q + 1'b1;
              if ((LOOPS != 0) && (pass_cnt_d == LOOPS_C)) begin
                state_d   = S_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                vec_idx_d = 2'd0;
              end
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
          // Sample strobe is registered, so it is derived from the next dwell value.
          if (state_d == S_DRIVE) vec_valid_d = (dwell_d == DWELL_LAST);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_idx_q   <= 2'd0;
      dwell_q     <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      dwell_q     <= dwell_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

  assign a         = vec_idx_q[1];
  assign b         = vec_idx_q[0];
  assign vec_idx   = vec_idx_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_cnt_q;
  assign dbg_state = state_q;

`ifdef GATE_SEQ_CHECK_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [1:0] first_err_q, first_err_d;
  logic [6:0] exp_y;
  logic       check_hit;

  always_comb begin
    exp_y       = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    check_hit   = (state_q == S_DRIVE) && vec_valid_q && (y != exp_y);
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (start_acc) begin
      err_cnt_d   = 8'd0;
      first_err_d = 2'd0;
    end else if (check_hit) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (err_cnt_q == 8'd0)  first_err_d = vec_idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q   <= 8'd0;
      first_err_q <= 2'd0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;
`endif

endmodule

// File: tb/tb_gate_stim_seq.sv
// Bench for gate_stim_seq: four parameterisations driven together, checked every cycle
// against an elapsed-time model of the vector schedule.
module tb_gate_stim_seq;

  localparam int NI = 4;
  localparam int DWS[NI] = '{4, 2, 1, 3};
  localparam int LPS[NI] = '{0, 1, 3, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] stop  = '0;

  logic [NI-1:0] a_o, b_o, valid_o, busy_o, done_o;
  logic [1:0]    idx_o  [NI];
  logic [15:0]   pass_o [NI];
  logic [1:0]    st_o   [NI];
`ifdef GATE_SEQ_CHECK_EN
  logic [6:0]    y_i    [NI];
  logic [7:0]    err_o  [NI];
  logic [1:0]    first_o[NI];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase 0 idle, 1 driving, 2 done; t = cycles elapsed since the first DRIVE cycle
  int m_ph[NI], m_t[NI], m_pass[NI], m_err[NI], m_first[NI];
  logic [6:0] f_mask[NI] = '{7'h00, 7'h10, 7'h40, 7'h00};
  logic [6:0] f_val [NI] = '{7'h00, 7'h00, 7'h40, 7'h00};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gate_stim_seq #(.DWELL(DWS[g]), .LOOPS(LPS[g]), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .stop(stop[g]),
`ifdef GATE_SEQ_CHECK_EN
      .y(y_i[g]), .err_cnt(err_o[g]), .first_err_idx(first_o[g]),
`endif
      .a(a_o[g]), .b(b_o[g]), .vec_idx(idx_o[g]), .vec_valid(valid_o[g]),
      .busy(busy_o[g]), .done(done_o[g]), .pass_cnt(pass_o[g]), .dbg_state(st_o[g])
    );
  end

  function automatic logic [6:0] gate_ref(input int v);
    logic av, bv;
    av = v[1];
    bv = v[0];
    return {~av, ~(av ^ bv), av ^ bv, ~(av | bv), ~(av & bv), av | bv, av & bv};
  endfunction

  function automatic logic [6:0] gate_drv(input int k, input int v);
    return (gate_ref(v) & ~f_mask[k]) | (f_val[k] & f_mask[k]);
  endfunction

`ifdef GATE_SEQ_CHECK_EN
  always_comb begin
    for (int k = 0; k < NI; k++) y_i[k] = gate_drv(k, int'({a_o[k], b_o[k]}));
  end
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_ph[k] = 0; m_t[k] = 0; m_pass[k] = 0; m_err[k] = 0; m_first[k] = 0;
    end
  endtask

  // Effect of the coming rising edge given the inputs currently applied.
  task automatic model_advance();
    int d, v;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      d = DWS[k];
      case (m_ph[k])
        0: if (start[k] && !stop[k]) begin
             m_ph[k] = 1; m_t[k] = 0; m_pass[k] = 0; m_err[k] = 0; m_first[k] = 0;
           end
        1: begin
             v = (m_t[k] / d) % 4;
             if ((m_t[k] % d == d - 1) && (gate_drv(k, v) != gate_ref(v))) begin
               if (m_err[k] == 0) m_first[k] = v;
               if (m_err[k] < 255) m_err[k]++;
             end
             if (stop[k]) begin
               m_ph[k] = 0;
               m_pass[k] = (m_t[k] / (4 * d)) % 65536;
             end else begin
               m_t[k]++;
               if (LPS[k] != 0 && m_t[k] == 4 * d * LPS[k]) begin
                 m_ph[k] = 2;
                 m_pass[k] = LPS[k];
               end
             end
           end
        default: m_ph[k] = 0;
      endcase
    end
  endtask

  task automatic check_all();
    int d, e_idx, e_pass;
    for (int k = 0; k < NI; k++) begin
      d = DWS[k];
      e_idx  = (m_ph[k] == 1) ? (m_t[k] / d) % 4 : 0;
      e_pass = (m_ph[k] == 1) ? (m_t[k] / (4 * d)) % 65536 : m_pass[k];
      check($sformatf("i%0d_busy", k), int'(busy_o[k]), int'(m_ph[k] == 1));
      check($sformatf("i%0d_done", k), int'(done_o[k]), int'(m_ph[k] == 2));
      check($sformatf("i%0d_idx", k), int'(idx_o[k]), e_idx);
      check($sformatf("i%0d_a", k), int'(a_o[k]), (e_idx >> 1) & 1);
      check($sformatf("i%0d_b", k), int'(b_o[k]), e_idx & 1);
      check($sformatf("i%0d_valid", k), int'(valid_o[k]),
            int'(m_ph[k] == 1 && (m_t[k] % d) == d - 1));
      check($sformatf("i%0d_pass", k), int'(pass_o[k]), e_pass);
`ifdef GATE_SEQ_CHECK_EN
      check($sformatf("i%0d_err", k), int'(err_o[k]), m_err[k]);
      check($sformatf("i%0d_first", k), int'(first_o[k]), m_first[k]);
`endif
    end
  endtask

  task automatic cycle();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    // reset values with rst held across edges
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // start sampled at edge 0; cycle numbers below count from it
    start = '1; cycle(); start = '0;
    repeat (3) cycle();
    start = '1; cycle(); start = '0;   // ignored: all instances busy
    repeat (4) cycle();
    check("d2l1_done_c9", int'(done_o[1]), 1);
    check("d2l1_pass_c9", int'(pass_o[1]), 1);
`ifdef GATE_SEQ_CHECK_EN
    check("d2l1_err_c9", int'(err_o[1]), 2);
    check("d2l1_first_c9", int'(first_o[1]), 1);
`endif
    repeat (4) cycle();
    check("d1l3_done_c13", int'(done_o[2]), 1);
    check("d1l3_pass_c13", int'(pass_o[2]), 3);
    repeat (7) cycle();
    stop[3] = 1'b1; cycle(); stop = '0;
    check("d3_abort_busy", int'(busy_o[3]), 0);
    check("d3_abort_pass", int'(pass_o[3]), 1);
    check("d3_abort_done", int'(done_o[3]), 0);
    start[3] = 1'b1; stop[3] = 1'b1; cycle(); start = '0; stop = '0;
    check("d3_start_stop_idle", int'(busy_o[3]), 0);

    // async reset while the DWELL=4 instance is mid-run
    async_reset();
    cycle();
    check("d4_idle_after_rst", int'(busy_o[0]), 0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NI; k++) begin
        start[k] = ($urandom_range(0, 9) == 0);
        stop[k]  = ($urandom_range(0, 59) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        start = '0; stop = '0;
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
